// File: rtl/cdb_broadcaster.sv
// Writeback-side CDB producer: per-FU 2-entry completion FIFOs drained
// round-robin onto SS registered broadcast lanes of {ROB tag, result data}.
module cdb_broadcaster #(
  parameter  int NUM_FU    = 3,
  parameter  int SS        = 2,
  parameter  int ROB_DEPTH = 8,
  parameter  int DATA_W    = 32,
  localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  output logic [SS-1:0]            cdb_valid,
  output logic [SS*TAG_W-1:0]      cdb_tag,
  output logic [SS*DATA_W-1:0]     cdb_data
);

  localparam int             PTR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [PTR_W:0] NUM_FU_W = (PTR_W+1)'(NUM_FU);

  logic [TAG_W-1:0]     tag_q   [NUM_FU][2];
  logic [TAG_W-1:0]     tag_d   [NUM_FU][2];
  logic [DATA_W-1:0]    data_q  [NUM_FU][2];
  logic [DATA_W-1:0]    data_d  [NUM_FU][2];
  logic [1:0]           cnt_q   [NUM_FU];
  logic [1:0]           cnt_d   [NUM_FU];
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SS-1:0]        cdb_valid_q, cdb_valid_d;
  logic [SS*TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [SS*DATA_W-1:0] cdb_data_q, cdb_data_d;

  logic [NUM_FU-1:0]    grant;
  logic [NUM_FU-1:0]    push;
  logic [SS-1:0]        lane_vld;
  logic [PTR_W-1:0]     lane_src [SS];

  // Ready depends only on registered occupancy, never on this cycle's pop.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (cnt_q[i] < 2'd2) && !rst;
    end
  end

  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W:0]   nxt;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] last_idx;
    logic             taken;
    grant    = '0;
    lane_vld = '0;
    last_idx = '0;
    sum      = '0;
    nxt      = '0;
    idx      = '0;
    taken    = 1'b0;
    for (int k = 0; k < SS; k++) begin
      lane_src[k] = '0;
    end
    for (int j = 0; j < NUM_FU; j++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(j);
      if (sum >= NUM_FU_W) begin
        sum = sum - NUM_FU_W;
      end
      idx = sum[PTR_W-1:0];
      if ((cnt_q[idx] != 2'd0) && !(&lane_vld)) begin
        grant[idx] = 1'b1;
        last_idx   = idx;
        taken      = 1'b0;
        for (int k = 0; k < SS; k++) begin
          if (!taken && !lane_vld[k]) begin
            lane_vld[k] = 1'b1;
            lane_src[k] = idx;
            taken       = 1'b1;
          end
        end
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (|grant) begin
      nxt = {1'b0, last_idx} + (PTR_W+1)'(1);
      rr_ptr_d = (nxt >= NUM_FU_W) ? '0 : nxt[PTR_W-1:0];
    end
    if (flush) begin
      rr_ptr_d = '0;
    end
  end

  // Head-shift FIFOs: slot 0 is always the head, so a pop moves slot 1 down.
  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    push   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      push[i] = fu_valid[i] && fu_ready[i];
      if (grant[i]) begin
        tag_d[i][0]  = tag_q[i][1];
        data_d[i][0] = data_q[i][1];
        cnt_d[i]     = cnt_q[i] - 2'd1;
      end
      if (push[i]) begin
        if (cnt_d[i] == 2'd0) begin
          tag_d[i][0]  = fu_tag[i*TAG_W +: TAG_W];
          data_d[i][0] = fu_data[i*DATA_W +: DATA_W];
        end else begin
          tag_d[i][1]  = fu_tag[i*TAG_W +: TAG_W];
          data_d[i][1] = fu_data[i*DATA_W +: DATA_W];
        end
        cnt_d[i] = cnt_d[i] + 2'd1;
      end
      if (flush) begin
        cnt_d[i] = 2'd0;
      end
    end
  end

  always_comb begin
    cdb_valid_d = '0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    if (!flush) begin
      cdb_valid_d = lane_vld;
      for (int k = 0; k < SS; k++) begin
        if (lane_vld[k]) begin
          cdb_tag_d[k*TAG_W +: TAG_W]    = tag_q[lane_src[k]][0];
          cdb_data_d[k*DATA_W +: DATA_W] = data_q[lane_src[k]][0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        cnt_q[i] <= 2'd0;
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
    // Payload slots need no reset; occupancy alone decides what is live.
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

endmodule
